regfile_exec_ctrl: RTL

REGFILE_EXEC_CTRL -- requirements
Module: regfile_exec_ctrl

---
 rtl/regfile_exec_ctrl_if.sv | 34 +++
 rtl/regfile_exec_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/regfile_exec_ctrl_if.sv
// Bus between the execution controller and its environment: instruction
// handshake, register-file read/write ports, window select and status.
//   slave  : the controller side (regfile_exec_ctrl)
//   master : the instruction source / register file side
interface regfile_exec_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [1:0]        window;
  logic [1:0]        Ri;
  logic [1:0]        Rj;
  logic [DATA_W-1:0] writedata;
  logic              reg_write;
  logic              zero;
  logic              carry;
  logic              done;
  logic              illegal;

  modport slave (
    input  instr_valid, instr, read_data1, read_data2,
    output instr_ready, window, Ri, Rj, writedata, reg_write,
           zero, carry, done, illegal
  );

  modport master (
    output instr_valid, instr, read_data1, read_data2,
    input  instr_ready, window, Ri, Rj, writedata, reg_write,
           zero, carry, done, illegal
  );
endinterface

// File: rtl/regfile_exec_ctrl.sv
// Register-file execution controller. Accepts one 16-bit instruction at a
// time ([15:12] opcode, [11:10] ri, [9:8] rj, [7:0] imm), reads the operands
// through the register file's combinational ports, and either writes an ALU /
// MVI result back to Ri or updates the register window.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - regfile_exec_ctrl_if.slave (handshake, register-file ports, flags)
module regfile_exec_ctrl #(
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               rst,
  regfile_exec_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_MVI  = 4'b0101;
  localparam logic [3:0] OP_WINC = 4'b1000;
  localparam logic [3:0] OP_WDEC = 4'b1001;
  localparam logic [3:0] OP_WSET = 4'b1010;

  logic [1:0]        state_q, state_d;
  logic [15:0]       instr_q;
  logic [1:0]        window_q, window_d;
  logic [DATA_W-1:0] wdata_q;
  logic              zero_q, carry_q;

  logic [3:0]        op;
  logic [7:0]        imm;
  logic              wr_op;
  logic              ill_op;
  // One extra bit: carry out for ADD, borrow for SUB, zero otherwise.
  logic [DATA_W:0]   res;

  assign op  = instr_q[15:12];
  assign imm = instr_q[7:0];

  always_comb begin
    wr_op    = 1'b0;
    ill_op   = 1'b0;
    res      = '0;
    window_d = window_q;
    case (op)
      OP_ADD: begin
        wr_op = 1'b1;
        res   = {1'b0, bus.read_data1} + {1'b0, bus.read_data2};
      end
      OP_SUB: begin
        wr_op = 1'b1;
        res   = {1'b0, bus.read_data1} - {1'b0, bus.read_data2};
      end
      OP_AND: begin
        wr_op = 1'b1;
        res   = {1'b0, bus.read_data1 & bus.read_data2};
      end
      OP_OR: begin
        wr_op = 1'b1;
        res   = {1'b0, bus.read_data1 | bus.read_data2};
      end
      OP_MVI: begin
        wr_op = 1'b1;
        res   = (DATA_W+1)'(imm);
      end
      OP_NOP:  ;
      OP_WINC: window_d = window_q + 2'd1;
      OP_WDEC: window_d = window_q - 2'd1;
      OP_WSET: window_d = imm[1:0];
      default: ill_op = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.instr_valid) state_d = READ;
      READ:    state_d = wr_op ? WB : IDLE;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      window_q <= '0;
      wdata_q  <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state_q == READ) begin
        if (wr_op) begin
          wdata_q <= res[DATA_W-1:0];
          carry_q <= res[DATA_W];
          zero_q  <= (res[DATA_W-1:0] == '0);
        end else begin
          window_q <= window_d;
        end
      end
    end
  end

  // Ri/Rj come straight from the latched instruction so they stay stable
  // through READ and WB (the write address is Ri).
  assign bus.instr_ready = (state_q == IDLE);
  assign bus.window      = window_q;
  assign bus.Ri          = instr_q[11:10];
  assign bus.Rj          = instr_q[9:8];
  assign bus.writedata   = wdata_q;
  assign bus.reg_write   = (state_q == WB);
  assign bus.zero        = zero_q;
  assign bus.carry       = carry_q;
  assign bus.done        = (state_q == WB) || (state_q == READ && !wr_op);
  assign bus.illegal     = (state_q == READ) && ill_op;

endmodule
